eth_rx_frame_ctrl: RTL

Receive-side frame controller placed directly after the GMII/MII frame receiver. It takes the receiver's byte-wide AXI-Stream output, which has no backpressure, and stores each frame in an internal circular buffer. Only frames that end with no error are committed; errored, runt and oversize frames are rolled back. Committed frames, with the FCS stripped, are replayed on a ready/valid AXI-Stream master, and per-class frame counters are maintained.

---
 rtl/eth_rx_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_frame_ctrl.sv
// ------------------------------------------------------------------------------------------------
// eth_rx_frame_ctrl
//
// Receive-side frame controller. It sits behind a GMII/MII frame receiver whose byte stream has
// no backpressure. Each incoming frame is written speculatively into a circular byte buffer.
// A frame is committed only if it ends cleanly: no tuser error, at least MIN_LEN bytes, at most
// MAX_LEN bytes, and it never hit a full buffer. Any other frame is rolled back.
// Committed frames are replayed on a ready/valid stream. When STRIP_FCS is set, the last 4
// bytes of each frame (the FCS) are removed.
//
// Ports
//   clk, rst                     single clock; asynchronous active-high reset
//   enable                       accept new frames (sampled on a frame's first beat only)
//   s_axis_t{data,valid,last,user}  receiver stream, no tready; tuser marks a bad frame
//   m_axis_t{data,valid,ready,last} replay stream
//   good_frames                  committed frames (saturating)
//   bad_frames                   frames dropped for tuser / runt / oversize (saturating)
//   overflow_frames              frames dropped because the buffer filled (saturating)
//   drop_pulse                   one-cycle pulse per rolled-back frame
// ------------------------------------------------------------------------------------------------
module eth_rx_frame_ctrl #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned STRIP_FCS  = 1,
    parameter int unsigned MIN_LEN    = 64,
    parameter int unsigned MAX_LEN    = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [31:0] good_frames,
    output logic [31:0] bad_frames,
    output logic [31:0] overflow_frames,
    output logic        drop_pulse
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StRecv, StDrop} wr_state_e;
    typedef enum logic [1:0] {ClsNone, ClsBad, ClsOvf} drop_cls_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
        return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // --------------------------------------------------------------------------------------------
    // State
    // --------------------------------------------------------------------------------------------
    wr_state_e              state_q, state_d;
    drop_cls_e              cls_q, cls_d;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  wr_commit_q, wr_commit_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [10:0]            len_q, len_d;
    logic                   err_q, err_d;
    // Delay line: [7:0] newest byte, [31:24] oldest byte.
    logic [31:0]            dl_q, dl_d;
    logic [2:0]             dl_cnt_q, dl_cnt_d;
    logic [31:0]            good_q, good_d;
    logic [31:0]            bad_q, bad_d;
    logic [31:0]            ovf_q, ovf_d;
    logic                   drop_q, drop_d;

    logic                   ram_vld_q, ram_vld_d;
    logic [8:0]             ram_rdata_q;
    logic                   out_vld_q, out_vld_d;
    logic [8:0]             out_word_q, out_word_d;

    logic [8:0]             mem [Depth];

    // --------------------------------------------------------------------------------------------
    // Write side
    // --------------------------------------------------------------------------------------------
    logic                   first_beat;
    logic                   accept;
    logic [10:0]            len_inc;
    logic                   err_inc;
    logic [2:0]             cnt_eff;
    logic                   wr_need;
    logic [7:0]             wr_byte;
    logic                   full;
    logic                   oversize;
    logic                   runt;
    logic                   mem_we;
    logic [8:0]             mem_wdata;
    logic [ADDR_WIDTH-1:0]  wr_ptr_inc;
    logic                   good_inc, bad_inc, ovf_inc;

    always_comb begin
        first_beat = (state_q == StIdle);
        accept     = s_axis_tvalid && ((state_q == StRecv) || ((state_q == StIdle) && enable));
        len_inc    = first_beat ? 11'd1 : ((len_q == 11'h7FF) ? len_q : len_q + 11'd1);
        err_inc    = (!first_beat && err_q) || s_axis_tuser;
        cnt_eff    = first_beat ? 3'd0 : dl_cnt_q;
        // With FCS stripping, a byte reaches the RAM only once four newer bytes exist.
        wr_need    = (STRIP_FCS != 0) ? (cnt_eff == 3'd4) : 1'b1;
        wr_byte    = (STRIP_FCS != 0) ? dl_q[31:24] : s_axis_tdata;
        full       = ((wr_ptr_q + ADDR_WIDTH'(1)) == rd_ptr_q);
        oversize   = ({21'd0, len_inc} > MAX_LEN);
        runt       = ({21'd0, len_inc} < MIN_LEN);
        wr_ptr_inc = wr_ptr_q + ADDR_WIDTH'(1);
    end

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        len_d       = len_q;
        err_d       = err_q;
        dl_d        = dl_q;
        dl_cnt_d    = dl_cnt_q;
        mem_we      = 1'b0;
        mem_wdata   = {s_axis_tlast, wr_byte};
        good_inc    = 1'b0;
        bad_inc     = 1'b0;
        ovf_inc     = 1'b0;
        drop_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Frame seen while disabled: swallow it silently, no class.
                if (s_axis_tvalid && !enable) begin
                    cls_d   = ClsNone;
                    state_d = s_axis_tlast ? StIdle : StDrop;
                end
            end
            StDrop: begin
                wr_ptr_d = wr_commit_q;
                if (s_axis_tvalid && s_axis_tlast) begin
                    bad_inc = (cls_q == ClsBad);
                    ovf_inc = (cls_q == ClsOvf);
                    drop_d  = (cls_q != ClsNone);
                    state_d = StIdle;
                end
            end
            default: ;
        endcase

        if (accept) begin
            len_d    = len_inc;
            err_d    = err_inc;
            dl_d     = {dl_q[23:0], s_axis_tdata};
            dl_cnt_d = (cnt_eff == 3'd4) ? 3'd4 : cnt_eff + 3'd1;
            state_d  = StRecv;

            if (wr_need && full) begin
                wr_ptr_d = wr_commit_q;
                if (s_axis_tlast) begin
                    ovf_inc = 1'b1;
                    drop_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cls_d   = ClsOvf;
                    state_d = StDrop;
                end
            end else if (oversize) begin
                wr_ptr_d = wr_commit_q;
                if (s_axis_tlast) begin
                    bad_inc = 1'b1;
                    drop_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cls_d   = ClsBad;
                    state_d = StDrop;
                end
            end else begin
                mem_we = wr_need;
                if (s_axis_tlast) begin
                    state_d = StIdle;
                    if (err_inc || runt) begin
                        wr_ptr_d = wr_commit_q;
                        bad_inc  = 1'b1;
                        drop_d   = 1'b1;
                    end else begin
                        wr_ptr_d    = wr_need ? wr_ptr_inc : wr_ptr_q;
                        wr_commit_d = wr_need ? wr_ptr_inc : wr_ptr_q;
                        good_inc    = 1'b1;
                    end
                end else if (wr_need) begin
                    wr_ptr_d = wr_ptr_inc;
                end
            end
        end

        good_d = sat_inc(good_q, good_inc);
        bad_d  = sat_inc(bad_q, bad_inc);
        ovf_d  = sat_inc(ovf_q, ovf_inc);
    end

    // --------------------------------------------------------------------------------------------
    // Read side: RAM output stage feeding a one-entry output register
    // --------------------------------------------------------------------------------------------
    logic avail;
    logic s1_move;
    logic out_pop;
    logic rd_en;

    always_comb begin
        avail   = (rd_ptr_q != wr_commit_q);
        out_pop = out_vld_q && m_axis_tready;
        s1_move = ram_vld_q && (!out_vld_q || m_axis_tready);
        // Issue a read whenever the RAM stage will be free at the next edge.
        rd_en   = avail && (!ram_vld_q || s1_move);

        rd_ptr_d   = rd_en ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        ram_vld_d  = rd_en ? 1'b1 : (s1_move ? 1'b0 : ram_vld_q);
        out_vld_d  = out_vld_q;
        out_word_d = out_word_q;
        if (s1_move) begin
            out_vld_d  = 1'b1;
            out_word_d = ram_rdata_q;
        end else if (out_pop) begin
            out_vld_d  = 1'b0;
        end
    end

    // --------------------------------------------------------------------------------------------
    // Storage
    // --------------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= mem_wdata;
        end
        if (rd_en) begin
            ram_rdata_q <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cls_q       <= ClsNone;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            dl_q        <= '0;
            dl_cnt_q    <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            ovf_q       <= '0;
            drop_q      <= 1'b0;
            ram_vld_q   <= 1'b0;
            out_vld_q   <= 1'b0;
            out_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            len_q       <= len_d;
            err_q       <= err_d;
            dl_q        <= dl_d;
            dl_cnt_q    <= dl_cnt_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            ram_vld_q   <= ram_vld_d;
            out_vld_q   <= out_vld_d;
            out_word_q  <= out_word_d;
        end
    end

    assign m_axis_tvalid   = out_vld_q;
    assign m_axis_tdata    = out_word_q[7:0];
    assign m_axis_tlast    = out_word_q[8];
    assign good_frames     = good_q;
    assign bad_frames      = bad_q;
    assign overflow_frames = ovf_q;
    assign drop_pulse      = drop_q;

endmodule
